mux_array_multiplier: RTL and testbench
=======================================

MUX_ARRAY_MULTIPLIER -- requirements
Module: mux_array_multiplier

Interface
REQ-001: The block SHALL have parameter SIZE, default 4, giving the operand width in bits; legal range 3..16.
REQ-002: The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset as elsewhere in the codebase.
REQ-003: Port clk, input, 1 bit; the single clock, with all state updated on its rising edge.
REQ-004: Port reset, input, 1 bit; asynchronous, active-high; clears all state.
REQ-005: Port in_valid, input, 1 bit; qualifies x and y in the current cycle.
REQ-006: Port x, input, SIZE bits; unsigned multiplicand.
REQ-007: Port y, input, SIZE bits; unsigned multiplier.
REQ-008: Port out_valid, output, 1 bit; p holds a valid product.
REQ-009: Port p, output, 2*SIZE bits; unsigned product, registered.

Function
REQ-010: The block SHALL compute p = x * y as an unsigned full-width product; overflow is impossible and there is no truncation or saturation.
REQ-011: The arithmetic core SHALL be combinational and SHALL be built as a symmetric array:
- diagonal cells (cell2 type) form the x[j]&y[j] terms and propagate the running sum and carry;
- off-diagonal cells (cell1 type) form the x[i]&y[j] + x[j]&y[i] pairs for i<j using mux-selected additions;
- 2-bit carry-lookahead adders (cla type) resolve product bit pairs p[2k], p[2k+1] for k = 1..SIZE-2, rippling their carry between stages, with carry-in 0 at k=1;
- a final full adder produces p[2*SIZE-2] and p[2*SIZE-1].
REQ-012: Product bit p[0] SHALL equal x[0]&y[0], and p[1] SHALL come from the first cell1 stage, with no CLA involved for either bit.
REQ-013: Only the functional result of REQ-010 is verified at the port; the internal cell partitioning in REQ-011 is mandatory for implementation but is not port-observable.
REQ-014: Latency SHALL be exactly 1 clock: on each rising edge with in_valid=1, p SHALL load x*y of that cycle and out_valid SHALL become 1.
REQ-015: On a rising edge with in_valid=0, out_valid SHALL become 0 and p SHALL hold its previous value.
REQ-016: Throughput SHALL be one product per clock; back-to-back valid inputs SHALL each produce a result exactly one cycle later, with no stalls and no backpressure.
REQ-017: Operands of 0 SHALL yield p=0.
REQ-018: All-ones operands SHALL yield (2^SIZE-1)^2.
REQ-019: Outputs SHALL be glitch-free register outputs; there SHALL be no combinational path from any input to p or out_valid.

Reset
REQ-020: While reset=1, p SHALL be 0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-021: If reset asserts while a valid result is pending, that result SHALL be discarded.
REQ-022: The first rising edge after reset deasserts SHALL behave per REQ-014 and REQ-015.
REQ-023: The core SHALL hold no state; reset affects only the output registers.

Verification
REQ-024: Exhaustive check at SIZE=3: apply all 64 {x,y} combinations with in_valid=1 on consecutive cycles -> each p equals x*y one cycle later, and 64/64 are correct.
REQ-025: SIZE=4, x=15, y=15 -> p=225 (8'hE1) with out_valid=1 after 1 clock; x=0, y=13 -> p=0.
REQ-026: SIZE=4, back-to-back inputs (3,5), (7,9), (12,11) -> p = 15, 63, 132 on three consecutive cycles.
REQ-027: SIZE=4, inputs with in_valid=0 -> out_valid=0 and p unchanged from the prior result, even if x and y change.
REQ-028: Assert reset asynchronously mid-cycle while p=225 -> p=0 and out_valid=0 immediately; after release, x=2, y=3 -> p=6 one clock later.
REQ-029: SIZE=8 random test of at least 10000 vectors against a reference model x*y -> zero mismatches, reporting any failing bit index.

Source files
------------

// File: rtl/mux_array_multiplier.sv
// mux_array_multiplier: registered unsigned multiplier built on a symmetric mux/carry-save array
module mux_array_multiplier #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [SIZE-1:0]   x,
  input  logic [SIZE-1:0]   y,
  output logic              out_valid,
  output logic [2*SIZE-1:0] p
);
  localparam int W = 2*SIZE;
  // Off-diagonal pair x[i]y[k] + x[k]y[i], each term mux-selected by the other operand bit
  function automatic logic [1:0] cell1(input logic xi, input logic yi, input logic xk, input logic yk);
    cell1 = {xk ? yi : 1'b0, yk ? xi : 1'b0};
  endfunction
  // Diagonal term x[k]y[k]
  function automatic logic cell2(input logic xk, input logic yk);
    cell2 = xk & yk;
  endfunction
  // 2-bit carry-lookahead adder: {carry_out, sum[1:0]}
  function automatic logic [2:0] cla(input logic [1:0] a, input logic [1:0] b, input logic ci);
    logic [1:0] g, t;
    logic c1;
    g = a & b;
    t = a ^ b;
    c1 = g[0] | (t[0] & ci);
    cla = {g[1] | (t[1] & g[0]) | (t[1] & t[0] & ci), t ^ {c1, ci}};
  endfunction
  // Full adder: {carry, sum}
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    fa = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction
  // Row k folds in every term whose larger index is k; sum/carry stay in carry-save form.
  // Carries shifted out of the top column are always zero since each vector never exceeds the product.
  for (genvar k = 0; k < SIZE; k++) begin : g_row
    logic [W-1:0] si, ci, u, v, s1, c1, so, co;
    if (k == 0) begin : g_first
      assign si = '0;
      assign ci = '0;
    end else begin : g_next
      assign si = g_row[k-1].so;
      assign ci = g_row[k-1].co;
    end
    // Gather the pair terms of row k and its diagonal term into two addend vectors
    always_comb begin
      u = '0;
      v = '0;
      for (int i = 0; i < k; i++) {v[i+k], u[i+k]} = cell1(x[i], y[i], x[k], y[k]);
      u[2*k] = cell2(x[k], y[k]);
    end
    assign s1 = si ^ ci ^ u;
    assign c1 = ((si & ci) | (si & u) | (ci & u)) << 1;
    assign so = s1 ^ c1 ^ v;
    assign co = ((s1 & c1) | (s1 & v) | (c1 & v)) << 1;
  end
  logic [W-1:0] a, b, prod;
  logic [1:0] top;
  assign a = g_row[SIZE-1].so;
  assign b = g_row[SIZE-1].co;
  // Bits 0 and 1 are already resolved by the array (carry vector is zero there)
  assign prod[1:0] = a[1:0] ^ b[1:0];
  for (genvar k = 1; k <= SIZE-2; k++) begin : g_cla
    logic ci, co;
    if (k == 1) begin : g_first
      assign ci = 1'b0;
    end else begin : g_next
      assign ci = g_cla[k-1].co;
    end
    assign {co, prod[2*k+1 -: 2]} = cla(a[2*k+1 -: 2], b[2*k+1 -: 2], ci);
  end
  assign top = fa(a[W-2], b[W-2], g_cla[SIZE-2].co);
  assign prod[W-2] = top[0];
  assign prod[W-1] = a[W-1] ^ b[W-1] ^ top[1];
  // Output register: load product on valid, otherwise hold p and drop out_valid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) p <= prod;
    end
endmodule

// File: tb/tb_mux_array_multiplier.sv
// tb_mux_array_multiplier: directed, exhaustive (SIZE=3) and random (SIZE=8) product checks
module tb_mux_array_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic iv3 = 1'b0, iv4 = 1'b0, iv8 = 1'b0;
  logic [2:0] x3 = '0, y3 = '0;
  logic [3:0] x4 = '0, y4 = '0;
  logic [7:0] x8 = '0, y8 = '0;
  logic [5:0] p3;
  logic [7:0] p4;
  logic [15:0] p8;
  logic ov3, ov4, ov8;
  int checks = 0;
  int errors = 0;

  mux_array_multiplier #(.SIZE(3)) u_m3 (.clk(clk), .reset(reset), .in_valid(iv3), .x(x3), .y(y3), .out_valid(ov3), .p(p3));
  mux_array_multiplier #(.SIZE(4)) u_m4 (.clk(clk), .reset(reset), .in_valid(iv4), .x(x4), .y(y4), .out_valid(ov4), .p(p4));
  mux_array_multiplier #(.SIZE(8)) u_m8 (.clk(clk), .reset(reset), .in_valid(iv8), .x(x8), .y(y8), .out_valid(ov8), .p(p8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (differing bits %0h)", tag, got, exp, got ^ exp);
    end
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic v);
    @(negedge clk);
    x4 = a;
    y4 = b;
    iv4 = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int good;
    #12;
    check("rst_p4", 64'(p4), 64'd0);
    check("rst_ov4", 64'(ov4), 64'd0);
    check("rst_p8", 64'({ov8, p8}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive4(4'd15, 4'd15, 1'b1);
    check("ones4_p", 64'(p4), 64'd225);
    check("ones4_ov", 64'(ov4), 64'd1);
    drive4(4'd0, 4'd13, 1'b1);
    check("zero_x", 64'(p4), 64'd0);
    drive4(4'd13, 4'd0, 1'b1);
    check("zero_y", 64'(p4), 64'd0);
    drive4(4'd3, 4'd5, 1'b1);
    check("b2b_0", 64'(p4), 64'd15);
    drive4(4'd7, 4'd9, 1'b1);
    check("b2b_1", 64'(p4), 64'd63);
    drive4(4'd12, 4'd11, 1'b1);
    check("b2b_2", 64'({ov4, p4}), 64'h184);
    drive4(4'd9, 4'd9, 1'b0);
    check("hold_ov", 64'(ov4), 64'd0);
    check("hold_p", 64'(p4), 64'd132);
    drive4(4'd1, 4'd2, 1'b0);
    check("hold_p2", 64'(p4), 64'd132);
    drive4(4'd15, 4'd15, 1'b1);
    check("pre_rst", 64'({ov4, p4}), 64'h1E1);
    #2;
    reset = 1'b1;
    #1;
    check("async_p", 64'(p4), 64'd0);
    check("async_ov", 64'(ov4), 64'd0);
    @(posedge clk);
    #1;
    check("rst_hold", 64'({ov4, p4}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive4(4'd2, 4'd3, 1'b1);
    check("post_rst", 64'({ov4, p4}), 64'h106);
    drive4(4'd10, 4'd6, 1'b1);
    check("mix4", 64'(p4), 64'd60);
    iv4 = 1'b0;
    good = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        x3 = 3'(a);
        y3 = 3'(b);
        iv3 = 1'b1;
        @(posedge clk);
        #1;
        if (ov3 && int'(p3) == a * b) good++;
        check("exh3", 64'({ov3, p3}), 64'({1'b1, 6'(a * b)}));
      end
    check("exh3_count", 64'(good), 64'd64);
    iv3 = 1'b0;
    @(negedge clk);
    x8 = 8'd255;
    y8 = 8'd255;
    iv8 = 1'b1;
    @(posedge clk);
    #1;
    check("ones8", 64'(p8), 64'd65025);
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] a, b;
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      x8 = a;
      y8 = b;
      @(posedge clk);
      #1;
      check("rnd8", 64'({ov8, p8}), 64'({1'b1, 16'(a) * 16'(b)}));
    end
    iv8 = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
